// File: rtl/sipo_pkg.sv
// Shared constants and status payload for the serial-in/parallel-out frame latch.
package sipo_pkg;

    localparam int unsigned SIPO_WIDTH_DEFAULT = 8;

    localparam bit SIPO_MSB_FIRST = 1'b1;
    localparam bit SIPO_LSB_FIRST = 1'b0;

    typedef struct packed {
        logic frame_full;
        logic overrun;
    } frame_status_t;

endpackage

// File: rtl/sipo_bit_counter.sv
// Saturating count of bits held in the shift register since the last latch.
module sipo_bit_counter
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH = SIPO_WIDTH_DEFAULT,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             Clock,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             full_c,
    output logic             at_last_c
);

    logic [CNT_W-1:0] count_q;

    // clr wins over inc: a bit shifted on a latch edge is consumed into the frame
    always_ff @(posedge Clock or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && !full_c) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count     = count_q;
    assign full_c    = (count_q == CNT_W'(WIDTH));
    assign at_last_c = (count_q >= CNT_W'(WIDTH - 1));

endmodule

// File: rtl/sipo_frame_latch.sv
// Serial-in/parallel-out shift register with frame counting, latch strobe or
// automatic latch on a full frame, and a sticky overrun flag.
module sipo_frame_latch
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH     = SIPO_WIDTH_DEFAULT,
    parameter bit          MSB_FIRST = SIPO_MSB_FIRST,
    localparam int unsigned CNT_W    = $clog2(WIDTH + 1)
) (
    input  logic             Clock,
    input  logic             rst,
    input  logic             SI,
    input  logic             shift_en,
    input  logic             latch,
    input  logic             auto_mode,
    output logic [WIDTH-1:0] PO,
    output logic             po_valid,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             frame_full,
    output logic             overrun
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_next;
    logic [WIDTH-1:0] po_q;
    logic             po_valid_q;
    logic             overrun_q;
    logic             overrun_next;
    logic             do_latch_c;
    logic             full_c;
    logic             at_last_c;
    frame_status_t    status;

    sipo_bit_counter #(
        .WIDTH(WIDTH)
    ) u_bit_counter (
        .Clock    (Clock),
        .rst      (rst),
        .inc      (shift_en),
        .clr      (do_latch_c),
        .count    (bit_cnt),
        .full_c   (full_c),
        .at_last_c(at_last_c)
    );

    // Shift next-state; direction fixed at build time
    always_comb begin
        sr_next = sr_q;
        if (shift_en) begin
            if (MSB_FIRST) begin
                sr_next = {sr_q[WIDTH-2:0], SI};
            end else begin
                sr_next = {SI, sr_q[WIDTH-1:1]};
            end
        end
    end

    // Latch decision and overrun; a latch edge clears overrun even if a bit is lost on it
    always_comb begin
        do_latch_c   = latch | (auto_mode & shift_en & at_last_c);
        overrun_next = overrun_q | (shift_en & full_c);
        if (do_latch_c) begin
            overrun_next = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge rst) begin
        if (!rst) begin
            sr_q       <= '0;
            po_q       <= '0;
            po_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            sr_q       <= sr_next;
            po_valid_q <= do_latch_c;
            overrun_q  <= overrun_next;
            if (do_latch_c) begin
                po_q <= sr_next;
            end
        end
    end

    assign status.frame_full = full_c;
    assign status.overrun    = overrun_q;

    assign PO         = po_q;
    assign po_valid   = po_valid_q;
    assign frame_full = status.frame_full;
    assign overrun    = status.overrun;

endmodule

// File: tb/tb_sipo_frame_latch.sv
// Directed bench for sipo_frame_latch: MSB-first and LSB-first builds side by side,
// checked every cycle against a bit-history model plus hand-computed frames.
module tb_sipo_frame_latch;

    localparam int W = 8;

    logic       Clock;
    logic       rst;
    logic       SI;
    logic       shift_en;
    logic       latch;
    logic       auto_mode;

    logic [7:0] po_m, po_l;
    logic       pv_m, pv_l;
    logic [3:0] cnt_m, cnt_l;
    logic       ff_m, ff_l;
    logic       ov_m, ov_l;

    int total = 0;
    int bad   = 0;

    sipo_frame_latch #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .Clock(Clock), .rst(rst), .SI(SI), .shift_en(shift_en), .latch(latch),
        .auto_mode(auto_mode), .PO(po_m), .po_valid(pv_m), .bit_cnt(cnt_m),
        .frame_full(ff_m), .overrun(ov_m)
    );

    sipo_frame_latch #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .Clock(Clock), .rst(rst), .SI(SI), .shift_en(shift_en), .latch(latch),
        .auto_mode(auto_mode), .PO(po_l), .po_valid(pv_l), .bit_cnt(cnt_l),
        .frame_full(ff_l), .overrun(ov_l)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Model: history of received bits (newest at the back) and a frame bit count
    bit         hist[$];
    int         m_cnt = 0;
    logic [7:0] m_po_m = '0;
    logic [7:0] m_po_l = '0;
    logic       m_pv = 1'b0;
    logic       m_ov = 1'b0;

    function automatic logic [7:0] frame(input bit msb);
        logic [7:0] f;
        bit b;
        f = '0;
        for (int i = 0; i < W; i++) begin
            b = (hist.size() > i) ? hist[hist.size() - 1 - i] : 1'b0;
            if (msb) f[i] = b;
            else     f[W - 1 - i] = b;
        end
        return f;
    endfunction

    always @(posedge Clock or negedge rst) begin
        if (!rst) begin
            hist.delete();
            m_cnt  = 0;
            m_po_m = '0;
            m_po_l = '0;
            m_pv   = 1'b0;
            m_ov   = 1'b0;
        end else begin
            bit lat;
            lat = latch || (auto_mode && shift_en && (m_cnt >= W - 1));
            if (shift_en) begin
                hist.push_back(SI);
                if (hist.size() > W) void'(hist.pop_front());
            end
            if (lat) begin
                m_po_m = frame(1'b1);
                m_po_l = frame(1'b0);
                m_pv   = 1'b1;
                m_cnt  = 0;
                m_ov   = 1'b0;
            end else begin
                m_pv = 1'b0;
                if (shift_en) begin
                    if (m_cnt == W) m_ov = 1'b1;
                    else            m_cnt = m_cnt + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle compare, mid-cycle away from the active edge
    always @(negedge Clock) begin
        chk("m.PO",         32'(po_m),  32'(m_po_m));
        chk("m.po_valid",   32'(pv_m),  32'(m_pv));
        chk("m.bit_cnt",    32'(cnt_m), 32'(m_cnt));
        chk("m.frame_full", 32'(ff_m),  32'(m_cnt == W));
        chk("m.overrun",    32'(ov_m),  32'(m_ov));
        chk("l.PO",         32'(po_l),  32'(m_po_l));
        chk("l.po_valid",   32'(pv_l),  32'(m_pv));
        chk("l.bit_cnt",    32'(cnt_l), 32'(m_cnt));
        chk("l.frame_full", 32'(ff_l),  32'(m_cnt == W));
        chk("l.overrun",    32'(ov_l),  32'(m_ov));
    end

    task automatic step(input logic si, input logic se, input logic la, input logic am);
        SI        = si;
        shift_en  = se;
        latch     = la;
        auto_mode = am;
        @(posedge Clock);
        #1;
    endtask

    task automatic shift_byte(input logic [7:0] b, input logic am);
        for (int i = 7; i >= 0; i--) step(b[i], 1'b1, 1'b0, am);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; SI = 1'b0; shift_en = 1'b0; latch = 1'b0; auto_mode = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        chk("reset PO",      32'(po_m),  32'h0);
        chk("reset bit_cnt", 32'(cnt_m), 32'h0);
        chk("reset overrun", 32'(ov_m),  32'h0);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Manual latch of a full frame
        shift_byte(8'hB2, 1'b0);
        chk("t1 full",    32'(ff_m),  32'h1);
        chk("t1 cnt8",    32'(cnt_m), 32'd8);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t1 PO",      32'(po_m),  32'hB2);
        chk("t1 PO lsb",  32'(po_l),  32'h4D);
        chk("t1 pv",      32'(pv_m),  32'h1);
        chk("t1 cnt",     32'(cnt_m), 32'h0);
        chk("t1 full0",   32'(ff_m),  32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1 pv drop", 32'(pv_m),  32'h0);

        // Back-to-back automatic frames
        shift_byte(8'hA5, 1'b1);
        chk("t2 PO A5",   32'(po_m),  32'hA5);
        chk("t2 pv A5",   32'(pv_m),  32'h1);
        chk("t2 cnt A5",  32'(cnt_m), 32'h0);
        shift_byte(8'h3C, 1'b1);
        chk("t2 PO 3C",   32'(po_m),  32'h3C);
        chk("t2 pv 3C",   32'(pv_m),  32'h1);
        chk("t2 ovr",     32'(ov_m),  32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Saturation and overrun, cleared by latch
        shift_byte(8'hB2, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t3 ovr set", 32'(ov_m),  32'h1);
        chk("t3 cnt sat", 32'(cnt_m), 32'd8);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3 PO",      32'(po_m),  32'hCB);
        chk("t3 ovr clr", 32'(ov_m),  32'h0);

        // auto_mode rising while full latches on the next shift
        shift_byte(8'h0F, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("ar PO",      32'(po_m),  32'h1F);
        chk("ar pv",      32'(pv_m),  32'h1);
        chk("ar ovr",     32'(ov_m),  32'h0);

        // Shift and latch on the same edge, then re-latch with no new bits
        step(1'b1, 1'b1, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("t4 PO",      32'(po_m),  32'hAB);
        chk("t4 cnt",     32'(cnt_m), 32'h0);
        chk("t4 pv",      32'(pv_m),  32'h1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("relatch PO", 32'(po_m),  32'hAB);
        chk("relatch pv", 32'(pv_m),  32'h1);

        // Partial frames from reset, both directions
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t5 PO",      32'(po_m),  32'h05);
        chk("t5 PO lsb",  32'(po_l),  32'hA0);
        chk("t5 full",    32'(ff_m),  32'h0);
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t5b PO",     32'(po_m),  32'h07);
        chk("t5b PO lsb", 32'(po_l),  32'hE0);

        // Asynchronous reset mid-frame
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        chk("t6 PO",      32'(po_m),  32'h0);
        chk("t6 cnt",     32'(cnt_m), 32'h0);
        chk("t6 pv",      32'(pv_m),  32'h0);
        chk("t6 ovr",     32'(ov_m),  32'h0);
        @(posedge Clock);
        #1;
        rst = 1'b1;
        shift_byte(8'hFF, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t6 PO FF",   32'(po_m),  32'hFF);
        chk("t6 PO FF l", 32'(po_l),  32'hFF);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
